// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared cpu opcodes, load/store unit state and tag types
// Purpose: opcode constants shared with the decoder, the LSU state enum, and the
//          load tag carried from issue to response. No ports.
package cpu_pkg;

    // Memory opcodes in the shared 6-bit opcode space.
    localparam logic [5:0] OP_LDB  = 6'h20;
    localparam logic [5:0] OP_LDH  = 6'h21;
    localparam logic [5:0] OP_LDW  = 6'h22;
    localparam logic [5:0] OP_LDD  = 6'h23;
    localparam logic [5:0] OP_LDBU = 6'h24;
    localparam logic [5:0] OP_LDHU = 6'h25;
    localparam logic [5:0] OP_STB  = 6'h28;
    localparam logic [5:0] OP_STH  = 6'h29;
    localparam logic [5:0] OP_STW  = 6'h2A;
    localparam logic [5:0] OP_STD  = 6'h2B;

    typedef enum logic {
        LSU_IDLE = 1'b0,
        LSU_HOLD = 1'b1
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE   = 2'd0,
        SZ_HALF   = 2'd1,
        SZ_WORD   = 2'd2,
        SZ_DOUBLE = 2'd3
    } lsu_size_t;

    // Everything needed to extract a load result once the bus returns the lane data.
    typedef struct packed {
        lsu_size_t  size;
        logic       sgn;
        logic [2:0] offset;
    } lsu_tag_t;

    localparam int LSU_TAG_W = $bits(lsu_tag_t);

    function automatic logic is_misaligned(input lsu_size_t size, input logic [2:0] low);
        case (size)
            SZ_HALF:   return low[0];
            SZ_WORD:   return |low[1:0];
            SZ_DOUBLE: return |low;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_lsu_fifo.sv
// rtl/cpu_lsu_fifo.sv - tag FIFO tracking outstanding loads in issue order
// Purpose: DEPTH-entry FIFO; a push on a full FIFO is accepted only with a
//          same-cycle pop, and a pop on an empty FIFO is ignored.
// Ports:   clock, reset (async, active-high); push/push_data write side;
//          pop/pop_data read side (pop_data is the current head); full, empty.
module cpu_lsu_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign pop_data = mem_q[rd_ptr_q];
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = do_push ? next_ptr(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
            end
        end
    end

endmodule

// File: rtl/cpu_lsu.sv
// rtl/cpu_lsu.sv - load/store unit between execute stage and data bus
// Purpose: computes the effective address, rejects misaligned ops, issues bus
//          requests (held stable while the bus is not ready), tracks outstanding
//          loads in a tag FIFO and extracts/extends in-order read responses.
// Ports:   clock, reset (async, active-high)
//          p3_*            execute-stage memory op, p4_jump_taken nullifies it
//          lsu_stall       pipeline hold, p3_misaligned_address alignment fault
//          bus_*           request/write/addr/byte_enable/wdata out, ready/rvalid/rdata in
//          ld_valid/ld_data load result, one cycle after bus_rvalid
module cpu_lsu
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    localparam int NB    = DATA_W / 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              p3_valid,
    input  logic [5:0]        p3_op,
    input  logic [31:0]       p3_data_a,
    input  logic [31:0]       p3_literal,
    input  logic [DATA_W-1:0] p3_data_b,
    input  logic              p4_jump_taken,
    output logic              lsu_stall,
    output logic              p3_misaligned_address,
    output logic              bus_request,
    output logic              bus_write,
    output logic [31:0]       bus_addr,
    output logic [NB-1:0]     bus_byte_enable,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ready,
    input  logic              bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              ld_valid,
    output logic [DATA_W-1:0] ld_data
);

    localparam int OFFW = $clog2(NB);

    lsu_state_t        state_q, state_d;
    logic [31:0]       hold_addr_q, hold_addr_d;
    logic [NB-1:0]     hold_be_q, hold_be_d;
    logic [DATA_W-1:0] hold_wdata_q, hold_wdata_d;
    logic              hold_write_q, hold_write_d;
    logic              hold_load_q, hold_load_d;
    lsu_tag_t          hold_tag_q, hold_tag_d;
    logic              ld_valid_q, ld_valid_d;
    logic [DATA_W-1:0] ld_data_q, ld_data_d;

    logic [31:0]       addr, addr_aligned;
    logic [OFFW-1:0]   offset;
    logic              op_load, op_store, op_sgn;
    lsu_size_t         op_size;
    logic [NB-1:0]     lane_mask, cur_be;
    logic [DATA_W-1:0] data_mask, cur_wdata;
    lsu_tag_t          cur_tag, push_tag, fifo_head;
    logic              is_mem, misalign, accept, issue, load_blocked;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;

    // Shift the addressed lanes down to bit 0, then sign/zero-extend per size.
    function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] d, input lsu_tag_t t);
        logic [DATA_W-1:0] s;
        logic [DATA_W-1:0] r;
        s = d >> {t.offset, 3'b000};
        r = s;
        case (t.size)
            SZ_BYTE: r = t.sgn ? DATA_W'($signed(s[7:0]))  : DATA_W'(s[7:0]);
            SZ_HALF: r = t.sgn ? DATA_W'($signed(s[15:0])) : DATA_W'(s[15:0]);
            SZ_WORD: r = t.sgn ? DATA_W'($signed(s[31:0])) : DATA_W'(s[31:0]);
            default: r = s;
        endcase
        return r;
    endfunction

    assign addr         = p3_data_a + p3_literal;
    assign offset       = addr[OFFW-1:0];
    assign addr_aligned = {addr[31:OFFW], {OFFW{1'b0}}};

    // Opcode decode; doubleword ops are only legal on a 64-bit bus.
    always_comb begin
        op_load  = 1'b0;
        op_store = 1'b0;
        op_sgn   = 1'b0;
        op_size  = SZ_BYTE;
        case (p3_op)
            OP_LDB:  begin op_load = 1'b1; op_sgn = 1'b1; end
            OP_LDH:  begin op_load = 1'b1; op_sgn = 1'b1; op_size = SZ_HALF; end
            OP_LDW:  begin op_load = 1'b1; op_sgn = 1'b1; op_size = SZ_WORD; end
            OP_LDBU: begin op_load = 1'b1; end
            OP_LDHU: begin op_load = 1'b1; op_size = SZ_HALF; end
            OP_LDD:  begin op_load = (DATA_W == 64); op_size = SZ_DOUBLE; end
            OP_STB:  begin op_store = 1'b1; end
            OP_STH:  begin op_store = 1'b1; op_size = SZ_HALF; end
            OP_STW:  begin op_store = 1'b1; op_size = SZ_WORD; end
            OP_STD:  begin op_store = (DATA_W == 64); op_size = SZ_DOUBLE; end
            default: ;
        endcase
    end

    always_comb begin
        lane_mask = '1;
        data_mask = '1;
        case (op_size)
            SZ_BYTE: begin lane_mask = NB'(1);     data_mask = DATA_W'(8'hFF);       end
            SZ_HALF: begin lane_mask = NB'(2'b11); data_mask = DATA_W'(16'hFFFF);    end
            SZ_WORD: begin lane_mask = NB'(4'hF);  data_mask = DATA_W'(32'hFFFF_FFFF); end
            default: ;
        endcase
        cur_be         = lane_mask << offset;
        cur_wdata      = op_store ? ((p3_data_b & data_mask) << {offset, 3'b000}) : '0;
        cur_tag.size   = op_size;
        cur_tag.sgn    = op_sgn;
        cur_tag.offset = 3'(offset);
    end

    assign is_mem                = p3_valid & (op_load | op_store) & ~p4_jump_taken;
    assign misalign              = is_misaligned(op_size, addr[2:0]);
    assign p3_misaligned_address = is_mem & misalign;
    assign accept                = is_mem & ~misalign & (state_q == LSU_IDLE);
    assign fifo_pop              = bus_rvalid & ~fifo_empty;
    // A pop in the same cycle frees the slot the new load needs.
    assign load_blocked          = op_load & fifo_full & ~fifo_pop;
    assign issue                 = accept & ~load_blocked;
    assign lsu_stall             = (state_q == LSU_HOLD) | (accept & load_blocked);

    // IDLE drives the request straight from execute; HOLD replays the latched copy.
    always_comb begin
        bus_request     = 1'b0;
        bus_write       = 1'b0;
        bus_addr        = '0;
        bus_byte_enable = '0;
        bus_wdata       = '0;
        if (state_q == LSU_HOLD) begin
            bus_request     = 1'b1;
            bus_write       = hold_write_q;
            bus_addr        = hold_addr_q;
            bus_byte_enable = hold_be_q;
            bus_wdata       = hold_wdata_q;
        end else if (issue) begin
            bus_request     = 1'b1;
            bus_write       = op_store;
            bus_addr        = addr_aligned;
            bus_byte_enable = cur_be;
            bus_wdata       = cur_wdata;
        end
    end

    assign fifo_push = bus_ready & ((state_q == LSU_HOLD) ? hold_load_q : (issue & op_load));
    assign push_tag  = (state_q == LSU_HOLD) ? hold_tag_q : cur_tag;

    always_comb begin
        state_d      = state_q;
        hold_addr_d  = hold_addr_q;
        hold_be_d    = hold_be_q;
        hold_wdata_d = hold_wdata_q;
        hold_write_d = hold_write_q;
        hold_load_d  = hold_load_q;
        hold_tag_d   = hold_tag_q;
        case (state_q)
            LSU_IDLE: begin
                if (issue && !bus_ready) begin
                    state_d      = LSU_HOLD;
                    hold_addr_d  = addr_aligned;
                    hold_be_d    = cur_be;
                    hold_wdata_d = cur_wdata;
                    hold_write_d = op_store;
                    hold_load_d  = op_load;
                    hold_tag_d   = cur_tag;
                end
            end
            LSU_HOLD: begin
                if (bus_ready) begin
                    state_d = LSU_IDLE;
                end
            end
            default: state_d = LSU_IDLE;
        endcase
        ld_valid_d = fifo_pop;
        ld_data_d  = fifo_pop ? extract(bus_rdata, fifo_head) : ld_data_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= LSU_IDLE;
            hold_addr_q  <= '0;
            hold_be_q    <= '0;
            hold_wdata_q <= '0;
            hold_write_q <= 1'b0;
            hold_load_q  <= 1'b0;
            hold_tag_q   <= '0;
            ld_valid_q   <= 1'b0;
            ld_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            hold_addr_q  <= hold_addr_d;
            hold_be_q    <= hold_be_d;
            hold_wdata_q <= hold_wdata_d;
            hold_write_q <= hold_write_d;
            hold_load_q  <= hold_load_d;
            hold_tag_q   <= hold_tag_d;
            ld_valid_q   <= ld_valid_d;
            ld_data_q    <= ld_data_d;
        end
    end

    assign ld_valid = ld_valid_q;
    assign ld_data  = ld_data_q;

    cpu_lsu_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (LSU_TAG_W)
    ) u_tag_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (push_tag),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_cpu_lsu.sv
// tb/tb_cpu_lsu.sv - directed self-checking bench for cpu_lsu (32- and 64-bit instances)
module tb_cpu_lsu;
    import cpu_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset;

    logic        p3_valid, p4_jump_taken, lsu_stall, p3_mis, bus_request, bus_write;
    logic [5:0]  p3_op;
    logic [31:0] p3_data_a, p3_literal, p3_data_b, bus_addr, bus_wdata, bus_rdata, ld_data;
    logic [3:0]  bus_be;
    logic        bus_ready, bus_rvalid, ld_valid;

    logic        w_p3_valid, w_p4_jump_taken, w_lsu_stall, w_p3_mis, w_bus_request, w_bus_write;
    logic [5:0]  w_p3_op;
    logic [31:0] w_p3_data_a, w_p3_literal, w_bus_addr;
    logic [63:0] w_p3_data_b, w_bus_wdata, w_bus_rdata, w_ld_data;
    logic [7:0]  w_bus_be;
    logic        w_bus_ready, w_bus_rvalid, w_ld_valid;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];

    cpu_lsu #(.DATA_W(32), .DEPTH(2)) u_dut32 (
        .clock(clock), .reset(reset), .p3_valid(p3_valid), .p3_op(p3_op),
        .p3_data_a(p3_data_a), .p3_literal(p3_literal), .p3_data_b(p3_data_b),
        .p4_jump_taken(p4_jump_taken), .lsu_stall(lsu_stall), .p3_misaligned_address(p3_mis),
        .bus_request(bus_request), .bus_write(bus_write), .bus_addr(bus_addr),
        .bus_byte_enable(bus_be), .bus_wdata(bus_wdata), .bus_ready(bus_ready),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .ld_valid(ld_valid), .ld_data(ld_data)
    );

    cpu_lsu #(.DATA_W(64), .DEPTH(2)) u_dut64 (
        .clock(clock), .reset(reset), .p3_valid(w_p3_valid), .p3_op(w_p3_op),
        .p3_data_a(w_p3_data_a), .p3_literal(w_p3_literal), .p3_data_b(w_p3_data_b),
        .p4_jump_taken(w_p4_jump_taken), .lsu_stall(w_lsu_stall), .p3_misaligned_address(w_p3_mis),
        .bus_request(w_bus_request), .bus_write(w_bus_write), .bus_addr(w_bus_addr),
        .bus_byte_enable(w_bus_be), .bus_wdata(w_bus_wdata), .bus_ready(w_bus_ready),
        .bus_rvalid(w_bus_rvalid), .bus_rdata(w_bus_rdata), .ld_valid(w_ld_valid), .ld_data(w_ld_data)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every ld_valid from the 32-bit unit must match the oldest expectation.
    always @(negedge clock) begin
        if (!reset && ld_valid) begin
            if (sb.size() == 0) check("sb_unexpected_ld_valid", ld_valid, 1'b0);
            else                check("sb_ld_data", ld_data, sb.pop_front());
        end
    end

    task automatic idle32();
        p3_valid = 0; p3_op = '0; p3_data_a = '0; p3_literal = '0; p3_data_b = '0;
        p4_jump_taken = 0; bus_ready = 0; bus_rvalid = 0; bus_rdata = '0;
    endtask

    task automatic idle64();
        w_p3_valid = 0; w_p3_op = '0; w_p3_data_a = '0; w_p3_literal = '0; w_p3_data_b = '0;
        w_p4_jump_taken = 0; w_bus_ready = 0; w_bus_rvalid = 0; w_bus_rdata = '0;
    endtask

    initial begin
        reset = 1; idle32(); idle64();
        repeat (2) @(negedge clock);
        #1;
        check("rst_req", bus_request, 0);  check("rst_write", bus_write, 0);
        check("rst_stall", lsu_stall, 0);  check("rst_ld_valid", ld_valid, 0);
        check("rst_ld_data", ld_data, 0);  check("rst_addr", bus_addr, 0);
        check("rst_be", bus_be, 0);        check("rst_wdata", bus_wdata, 0);
        @(negedge clock); reset = 0;

        // LDW 0x1000, response next cycle, result one cycle after response
        @(negedge clock); p3_valid = 1; p3_op = OP_LDW; p3_data_a = 32'h1000; bus_ready = 1; #1;
        check("ldw_req", bus_request, 1); check("ldw_addr", bus_addr, 32'h1000);
        check("ldw_write", bus_write, 0); check("ldw_stall", lsu_stall, 0);
        sb.push_back(32'h8000_00F1);
        @(negedge clock); p3_valid = 0; bus_rvalid = 1; bus_rdata = 32'h8000_00F1; #1;
        check("ldw_lat0", ld_valid, 0);
        @(negedge clock); bus_rvalid = 0; #1;
        check("ldw_lat1", ld_valid, 1); check("ldw_data", ld_data, 32'h8000_00F1);

        // LDB / LDBU at 0x1003 (address formed from base + literal)
        @(negedge clock); p3_valid = 1; p3_op = OP_LDB; p3_data_a = 32'h1000; p3_literal = 3; #1;
        check("ldb_addr", bus_addr, 32'h1000); check("ldb_be", bus_be, 4'b1000);
        sb.push_back(32'hFFFF_FF80);
        @(negedge clock); p3_op = OP_LDBU; bus_rvalid = 1; bus_rdata = 32'h8012_3456; #1;
        check("ldbu_req", bus_request, 1);
        sb.push_back(32'h0000_0080);
        @(negedge clock); p3_valid = 0; #1;
        check("ldb_data", ld_data, 32'hFFFF_FF80);
        @(negedge clock); bus_rvalid = 0; #1;
        check("ldbu_data", ld_data, 32'h0000_0080);

        // Three back-to-back loads with DEPTH=2: third waits for a pop
        @(negedge clock); idle32(); p3_valid = 1; p3_op = OP_LDW; p3_data_a = 32'h10; bus_ready = 1; #1;
        check("q1_req", bus_request, 1); check("q1_stall", lsu_stall, 0);
        sb.push_back(32'h1111_1111);
        @(negedge clock); p3_op = OP_LDH; p3_data_a = 32'h16; #1;
        check("q2_req", bus_request, 1); check("q2_be", bus_be, 4'b1100);
        sb.push_back(32'hFFFF_9ABC);
        @(negedge clock); p3_op = OP_LDHU; p3_data_a = 32'h1A; #1;
        check("q3_full_stall", lsu_stall, 1); check("q3_full_noreq", bus_request, 0);
        @(negedge clock); bus_rvalid = 1; bus_rdata = 32'h1111_1111; #1;
        check("q3_pop_req", bus_request, 1); check("q3_pop_stall", lsu_stall, 0);
        check("q3_pop_addr", bus_addr, 32'h18);
        sb.push_back(32'h0000_F00D);
        @(negedge clock); p3_valid = 0; bus_rdata = 32'h9ABC_0000; #1;
        @(negedge clock); bus_rdata = 32'hF00D_8765; #1;
        @(negedge clock); bus_rdata = 32'hDEAD_BEEF; #1;
        @(negedge clock); bus_rvalid = 0; #1;
        check("empty_rvalid_ignored", ld_valid, 0);

        // Misaligned ops and nullification by a taken jump
        @(negedge clock); p3_valid = 1; p3_op = OP_LDW; p3_data_a = 32'h1000; p3_literal = 2; #1;
        check("mis_ldw_flag", p3_mis, 1); check("mis_ldw_noreq", bus_request, 0);
        @(negedge clock); p4_jump_taken = 1; #1;
        check("mis_jump_flag", p3_mis, 0); check("mis_jump_noreq", bus_request, 0);
        @(negedge clock); p3_literal = 0; #1;
        check("jump_aligned_noreq", bus_request, 0);
        @(negedge clock); p4_jump_taken = 0; p3_op = OP_STH; p3_data_a = 32'h2001; #1;
        check("mis_sth_flag", p3_mis, 1); check("mis_sth_noreq", bus_request, 0);

        // STH 0x2002 with bus_ready low for 3 cycles, a new load waiting in p3
        @(negedge clock); idle32(); p3_valid = 1; p3_op = OP_STH; p3_data_a = 32'h2000;
        p3_literal = 2; p3_data_b = 32'hCAFE_1234; #1;
        check("sth_req", bus_request, 1);  check("sth_write", bus_write, 1);
        check("sth_be", bus_be, 4'b1100);  check("sth_wdata", bus_wdata, 32'h1234_0000);
        check("sth_stall", lsu_stall, 0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clock); p3_op = OP_LDW; p3_data_a = 32'h40; p3_literal = 0;
            p3_data_b = 32'h5A5A_5A5A; bus_ready = (i == 3); #1;
            check("hold_stall", lsu_stall, 1); check("hold_req", bus_request, 1);
            check("hold_write", bus_write, 1); check("hold_be", bus_be, 4'b1100);
            check("hold_wdata", bus_wdata, 32'h1234_0000); check("hold_addr", bus_addr, 32'h2000);
        end
        @(negedge clock); #1;
        check("post_hold_stall", lsu_stall, 0); check("post_hold_write", bus_write, 0);
        check("post_hold_addr", bus_addr, 32'h40);
        sb.push_back(32'h5555_AAAA);
        @(negedge clock); p3_valid = 0; bus_rvalid = 1; bus_rdata = 32'h5555_AAAA; #1;
        @(negedge clock); bus_rvalid = 0; #1;

        // Reset in HOLD with a load outstanding discards everything
        @(negedge clock); p3_valid = 1; p3_op = OP_LDW; p3_data_a = 32'h80; bus_ready = 1; #1;
        @(negedge clock); p3_op = OP_STW; p3_data_a = 32'h84; p3_data_b = 32'h0102_0304; bus_ready = 0; #1;
        check("pre_rst_req", bus_request, 1);
        @(negedge clock); p3_valid = 0; #1;
        check("pre_rst_hold_stall", lsu_stall, 1);
        reset = 1; #1;
        check("mid_rst_req", bus_request, 0); check("mid_rst_stall", lsu_stall, 0);
        check("mid_rst_ld_data", ld_data, 0);
        @(negedge clock); reset = 0; bus_ready = 1; bus_rvalid = 1; bus_rdata = 32'h7777_7777; #1;
        @(negedge clock); bus_rvalid = 0; #1;
        check("post_rst_rvalid_ignored", ld_valid, 0);
        idle32();

        // 64-bit bus: STB lane shift, LDH from the upper half, LDD, misaligned LDD
        @(negedge clock); w_p3_valid = 1; w_p3_op = OP_STB; w_p3_data_a = 32'h3000; w_p3_literal = 5;
        w_p3_data_b = 64'hFFFF_FFFF_FFFF_FFAB; w_bus_ready = 1; #1;
        check("w_stb_be", w_bus_be, 8'b0010_0000);
        check("w_stb_wdata", w_bus_wdata, 64'h0000_AB00_0000_0000);
        check("w_stb_addr", w_bus_addr, 32'h3000); check("w_stb_write", w_bus_write, 1);
        @(negedge clock); w_p3_op = OP_LDH; w_p3_data_a = 32'h1008; w_p3_literal = 6; #1;
        check("w_ldh_addr", w_bus_addr, 32'h1008); check("w_ldh_be", w_bus_be, 8'hC0);
        @(negedge clock); w_p3_op = OP_LDD; w_p3_literal = 0; w_bus_rvalid = 1;
        w_bus_rdata = 64'h8001_0000_0000_0000; #1;
        check("w_ldd_req", w_bus_request, 1); check("w_ldd_be", w_bus_be, 8'hFF);
        @(negedge clock); w_p3_valid = 0; w_bus_rdata = 64'h0123_4567_89AB_CDEF; #1;
        check("w_ldh_valid", w_ld_valid, 1); check("w_ldh_data", w_ld_data, 64'hFFFF_FFFF_FFFF_8001);
        @(negedge clock); w_bus_rvalid = 0; #1;
        check("w_ldd_data", w_ld_data, 64'h0123_4567_89AB_CDEF);
        @(negedge clock); w_p3_valid = 1; w_p3_op = OP_LDD; w_p3_data_a = 32'h100C; #1;
        check("w_ldd_mis_flag", w_p3_mis, 1); check("w_ldd_mis_noreq", w_bus_request, 0);
        @(negedge clock); idle64(); #1;

        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_lsu.md
CPU_LSU -- requirements
Module: cpu_lsu

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set bus data width; legal values are 32 and 64.
REQ-002 Parameter DEPTH, default 2, SHALL set the number of outstanding loads; legal values are 1 to 8.
REQ-003 Derived constant NB = DATA_W/8 SHALL be the byte-lane count.
REQ-004 clock  in  1  single clock for the block.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 p3_valid  in  1  memory op present in execute.
REQ-007 p3_op  in  6  LDB/LDH/LDW/LDBU/LDHU/STB/STH/STW (plus LDD/STD when DATA_W=64) in shared opcode encoding.
REQ-008 p3_data_a, p3_literal, p3_data_b  in  32,32,DATA_W  base, offset, store data.
REQ-009 p4_jump_taken  in  1  nullify the p3 op.
REQ-010 lsu_stall  out  1  pipeline hold request.
REQ-011 p3_misaligned_address  out  1  alignment fault, combinational.
REQ-012 bus_request, bus_write  out  1,1  request, write strobe; bus_ready  in  1  accept.
REQ-013 bus_addr  out  32  word-aligned address (low log2(NB) bits zero).
REQ-014 bus_byte_enable, bus_wdata  out  NB, DATA_W  lane enables, lane-shifted data.
REQ-015 bus_rvalid, bus_rdata  in  1, DATA_W  in-order read response.
REQ-016 ld_valid, ld_data  out  1, DATA_W  extracted, extended load result.

Function
REQ-017 Address SHALL be p3_data_a + p3_literal, mod 2^32.
REQ-018 Misaligned: halfword with addr[0]=1, word with addr[1:0]!=0, double with addr[2:0]!=0; misaligned ops SHALL NOT reach the bus.
REQ-019 p4_jump_taken SHALL suppress issue and force p3_misaligned_address=0 that cycle.
REQ-020 FSM states IDLE, HOLD: in IDLE an accepted op asserts bus_request same cycle; bus_ready=1 stays IDLE, bus_ready=0 latches request and goes to HOLD.
REQ-021 In HOLD bus_request and all bus outputs SHALL stay stable; lsu_stall=1; bus_ready=1 returns to IDLE.
REQ-022 A load SHALL push {size, signed, byte offset} into a DEPTH-entry FIFO when accepted by the bus.
REQ-023 A load arriving with the FIFO full (and no same-cycle pop) SHALL assert lsu_stall and not request.
REQ-024 Same-cycle push and pop on a full FIFO SHALL be permitted; count unchanged.
REQ-025 bus_rvalid SHALL pop FIFO head; ld_valid SHALL assert exactly one cycle later (1-cycle latency) with data shifted by offset, sign- or zero-extended per head.
REQ-026 bus_rvalid with empty FIFO SHALL be ignored.
REQ-027 Stores SHALL not enter the FIFO; byte enables and wdata lanes SHALL be shifted by addr offset; unused lanes zero.
REQ-028 FIFO pointers SHALL wrap modulo DEPTH.

Reset
REQ-029 On reset: state IDLE, FIFO empty, pointers zero, bus_request=0, bus_write=0, lsu_stall=0, ld_valid=0, ld_data=0, bus_addr/wdata/byte_enable=0.
REQ-030 Reset mid-HOLD or with loads outstanding SHALL discard all state; later rvalid ignored until a new load issues.

Structure
REQ-031 Opcode constants, lsu_state_t and lsu_tag_t (size, signed, offset) SHALL live in the shared cpu package.
REQ-032 The tag FIFO SHALL be a sub-module cpu_lsu_fifo parametrised by DEPTH and width.

Verification
REQ-033 LDW addr 0x1000, bus_ready=1, rdata 0x8000_00F1 next cycle -> ld_valid one cycle later, ld_data=0x8000_00F1.
REQ-034 LDB addr 0x1003, rdata 0x80xx_xxxx -> ld_data=0xFFFF_FF80; LDBU same -> 0x0000_0080.
REQ-035 STH addr 0x2002 data 0x1234, bus_ready low 3 cycles -> lsu_stall 3 cycles, byte_enable=1100, wdata[31:16]=0x1234 stable throughout.
REQ-036 DEPTH=2, three back-to-back loads no responses -> third stalls; one rvalid -> third issues same cycle as pop.
REQ-037 LDW addr 0x1002 -> p3_misaligned_address=1, no bus_request; with p4_jump_taken=1 -> neither asserted.
REQ-038 DATA_W=64, STB addr 0x3005 data 0xAB -> byte_enable=0010_0000, wdata[47:40]=0xAB, bus_addr=0x3000.
